// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch sequencer.
package fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int INST_W = 10;
  localparam logic [ADDR_W-1:0] RESET_PC  = 16'h0000;
  localparam logic [INST_W-1:0] HALT_INST = 10'b0000000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetchState_e;
endpackage

// File: rtl/rom_port_arb.sv
// Single ROM read port arbiter: fetch owns the port in unstalled, unredirected
// RUN; otherwise a pending debug read takes it.
module rom_port_arb
  import fetch_pkg::*;
(
  input  fetchState_e             state,
  input  logic                    stall,
  input  logic                    branchValid,
  input  logic                    dbgReq,
  input  logic [ADDR_W-1:0]       fetchPc,
  input  logic [ADDR_W-1:0]       dbgAddr,
  output logic [ADDR_W-1:0]       instAddress,
  output logic                    fetchOwn,
  output logic                    dbgGrant
);
  always_comb begin
    fetchOwn    = (state == RUN) && !stall && !branchValid;
    dbgGrant    = !fetchOwn && dbgReq;
    // With no requester the port idles on the fetch pointer (reads are side-effect free).
    instAddress = dbgGrant ? dbgAddr : fetchPc;
  end
endmodule

// File: rtl/inst_fetch_sequencer.sv
// PC / fetch controller for a combinational instruction ROM, with branch
// redirect, stall, halt detection and a shared debug read port.
module inst_fetch_sequencer
  import fetch_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchValid,
  input  logic [15:0]       BranchTarget,
  input  logic              DbgReq,
  input  logic [15:0]       DbgAddr,
  output logic [15:0]       InstAddress,
  input  logic [9:0]        InstIn,
  output logic [9:0]        InstOut,
  output logic              InstValid,
  output logic [15:0]       PC,
  output logic              DbgGnt,
  output logic [9:0]        DbgData,
  output logic              Halted,
  output logic              Busy,
  output logic [1:0]        FsmState
);
  // Debug handshake: DbgReq is a level request sampled every cycle; each cycle
  // the port is granted produces a one-cycle DbgGnt pulse on the following
  // cycle with DbgData holding the word read at DbgAddr. No ready/ack exists.

  fetchState_e       state, stateNext;
  logic [ADDR_W-1:0] fpc, fpcNext;
  logic [ADDR_W-1:0] pcNext;
  logic [INST_W-1:0] instOutNext;
  logic              instValidNext;
  logic              dbgGntNext;
  logic [INST_W-1:0] dbgDataNext;
  logic              fetchOwn;
  logic              dbgGrant;

  rom_port_arb uArb (
    .state       (state),
    .stall       (Stall),
    .branchValid (BranchValid),
    .dbgReq      (DbgReq),
    .fetchPc     (fpc),
    .dbgAddr     (DbgAddr),
    .instAddress (InstAddress),
    .fetchOwn    (fetchOwn),
    .dbgGrant    (dbgGrant)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext     = state;
    fpcNext       = fpc;
    pcNext        = PC;
    instOutNext   = InstOut;
    instValidNext = 1'b0;
    dbgGntNext    = dbgGrant;
    dbgDataNext   = dbgGrant ? InstIn : DbgData;
    case (state)
      IDLE: begin
        if (Start) begin
          stateNext = RUN;
          fpcNext   = RESET_PC;
        end
      end
      HALTED: begin
        // fpc still points at the halt word, so resume just past it.
        if (Start) begin
          stateNext = RUN;
          fpcNext   = fpc + 16'd1;
        end
      end
      RUN: begin
        if (BranchValid) begin
          fpcNext = BranchTarget;
        end else if (fetchOwn) begin
          pcNext = fpc;
          if (InstIn == HALT_INST) begin
            stateNext = HALTED;
          end else begin
            instOutNext   = InstIn;
            instValidNext = 1'b1;
            fpcNext       = fpc + 16'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fpc       <= RESET_PC;
      PC        <= RESET_PC;
      InstOut   <= '0;
      InstValid <= 1'b0;
      DbgGnt    <= 1'b0;
      DbgData   <= '0;
    end else begin
      fpc       <= fpcNext;
      PC        <= pcNext;
      InstOut   <= instOutNext;
      InstValid <= instValidNext;
      DbgGnt    <= dbgGntNext;
      DbgData   <= dbgDataNext;
    end
  end

  assign Halted   = (state == HALTED);
  assign Busy     = (state == RUN);
  assign FsmState = state;
endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed plus randomized bench for inst_fetch_sequencer against a behavioural fetch model.
module tb_inst_fetch_sequencer;
  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Stall;
  logic        BranchValid;
  logic [15:0] BranchTarget;
  logic        DbgReq;
  logic [15:0] DbgAddr;
  logic [15:0] InstAddress;
  logic [9:0]  InstIn;
  logic [9:0]  InstOut;
  logic        InstValid;
  logic [15:0] PC;
  logic        DbgGnt;
  logic [9:0]  DbgData;
  logic        Halted;
  logic        Busy;
  logic [1:0]  FsmState;

  logic [9:0] romMem [0:65535];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Behavioural model state
  logic        mRunning;
  logic        mHalted;
  logic [15:0] mFpc;
  logic [9:0]  eInst;
  logic        eValid;
  logic [15:0] ePc;
  logic        eGnt;
  logic [9:0]  eDbgData;

  inst_fetch_sequencer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Stall        (Stall),
    .BranchValid  (BranchValid),
    .BranchTarget (BranchTarget),
    .DbgReq       (DbgReq),
    .DbgAddr      (DbgAddr),
    .InstAddress  (InstAddress),
    .InstIn       (InstIn),
    .InstOut      (InstOut),
    .InstValid    (InstValid),
    .PC           (PC),
    .DbgGnt       (DbgGnt),
    .DbgData      (DbgData),
    .Halted       (Halted),
    .Busy         (Busy),
    .FsmState     (FsmState)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign InstIn = romMem[InstAddress];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mRunning = 1'b0;
    mHalted  = 1'b0;
    mFpc     = 16'h0000;
    eInst    = '0;
    eValid   = 1'b0;
    ePc      = 16'h0000;
    eGnt     = 1'b0;
    eDbgData = '0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".InstOut"},   {6'd0, InstOut},   {6'd0, eInst});
    check({ctx, ".InstValid"}, {15'd0, InstValid}, {15'd0, eValid});
    check({ctx, ".PC"},        PC,                ePc);
    check({ctx, ".DbgGnt"},    {15'd0, DbgGnt},   {15'd0, eGnt});
    check({ctx, ".DbgData"},   {6'd0, DbgData},   {6'd0, eDbgData});
    check({ctx, ".Halted"},    {15'd0, Halted},   {15'd0, mHalted});
    check({ctx, ".Busy"},      {15'd0, Busy},     {15'd0, mRunning});
  endtask

  // Driver: apply one cycle of inputs, check the ROM address, advance the model, check outputs.
  task automatic step(input logic st, input logic sl, input logic bv, input logic [15:0] bt,
                      input logic dr, input logic [15:0] da);
    logic        fetching;
    logic [15:0] addr;
    logic [9:0]  word;
    Start = st; Stall = sl; BranchValid = bv; BranchTarget = bt; DbgReq = dr; DbgAddr = da;
    #1;
    fetching = mRunning && !sl && !bv;
    addr     = fetching ? mFpc : (dr ? da : mFpc);
    word     = romMem[addr];
    check("InstAddress", InstAddress, addr);

    eGnt = !fetching && dr;
    if (eGnt) eDbgData = word;
    eValid = 1'b0;
    if (mRunning) begin
      if (bv) begin
        mFpc = bt;
      end else if (!sl) begin
        ePc = mFpc;
        if (word == 10'd0) begin
          mRunning = 1'b0;
          mHalted  = 1'b1;
        end else begin
          eInst  = word;
          eValid = 1'b1;
          mFpc   = mFpc + 16'd1;
        end
      end
    end else if (st) begin
      mFpc     = mHalted ? mFpc + 16'd1 : 16'h0000;
      mRunning = 1'b1;
      mHalted  = 1'b0;
    end
    @(posedge Clk);
    #1;
    check_outputs("step");
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) romMem[i] = 10'd0;
    for (int i = 0; i < 32; i++) romMem[i] = 10'($urandom_range(1, 1023));
    for (int i = 16'hFFF0; i <= 16'hFFFF; i++) romMem[i] = 10'($urandom_range(1, 1023));
    romMem[14] = 10'd0;

    Reset_n = 1'b0; Start = 1'b0; Stall = 1'b0; BranchValid = 1'b0;
    BranchTarget = '0; DbgReq = 1'b0; DbgAddr = '0;
    model_reset();
    #12;
    check("reset.InstAddress", InstAddress, 16'h0000);
    check_outputs("reset");
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Straight-line fetch of words 0..13 up to the halt word at 14
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (16) idle_step();
    check("halt.PC", PC, 16'd14);

    // Resume past the halt word, then two redirects (second while FPC=9)
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) idle_step();
    step(1'b0, 1'b0, 1'b1, 16'd7, 1'b0, 16'h0);
    repeat (2) idle_step();
    step(1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 16'h0);
    repeat (2) idle_step();
    check("branch.PC", PC, 16'd6);

    // Stall with debug reads of word 2, then resume at the same pointer
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'd2);
    check("stall.DbgData", {6'd0, DbgData}, {6'd0, romMem[2]});
    repeat (2) idle_step();

    // Wrap from 16'hFFFF to 0
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0);
    repeat (3) idle_step();
    check("wrap.PC", PC, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [15:0] tgt;
      logic [15:0] da;
      tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                        : 16'($urandom_range(0, 20));
      da  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 2) == 0), da);
    end

    // Asynchronous reset mid-RUN with stall and debug active
    step(1'b1, 1'b0, 1'b1, 16'd3, 1'b1, 16'd9);
    Stall = 1'b1; DbgReq = 1'b1; DbgAddr = 16'd3;
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(posedge Clk);
    #1;
    check_outputs("held_reset");
    Reset_n = 1'b1; Stall = 1'b0; DbgReq = 1'b0;
    idle_step();

    // Start together with debug from IDLE, then from HALTED
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'd4);
    repeat (3) idle_step();
    step(1'b0, 1'b0, 1'b1, 16'd12, 1'b0, 16'h0);
    repeat (3) idle_step();
    check("halt2.PC", PC, 16'd14);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'd5);
    repeat (2) idle_step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
